// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
//   state_t   : sequencer phase encoding (3-bit)
//   INST_*    : west-edge instruction codes driven into row 0
//   FMT_*     : dataflow select driven to every PE
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_KLOAD = 3'd2,
    S_KGAP  = 3'd3,
    S_EXEC  = 3'd4,
    S_DRAIN = 3'd5,
    S_FLUSH = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic FMT_WS = 1'b1;
  localparam logic FMT_OS = 1'b0;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter with a zero flag; times the length of each phase.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (wins over decrement)
//   load_val   : phase length minus one
//   zero_c     : counter currently reads zero (combinational from the register)
module seq_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Saturates at zero so idle phases simply hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Central sequencer for the ROW x COL mac_tile array. One accepted start runs
// one tile pass (WS: clear, kernel load, gap, execute, drain; OS: clear,
// execute, drain, flush) and pulses done once the array has drained.
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a pass (honoured only in IDLE)
//   mode_cfg     : requested dataflow, 1=WS 0=OS, latched on accepted start
//   num_vec      : activation vectors to stream, latched on accepted start
//   format       : latched dataflow to every PE
//   inst_w       : row-0 west instruction
//   overwrite    : one-cycle pulse re-arming PE load_ready
//   flush        : OS partial-sum drain window
//   mem_rd_en    : SRAM read strobe
//   mem_rd_addr  : SRAM read address
//   busy         : pass in progress (low in IDLE and DONE)
//   done         : one-cycle completion pulse
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ROW    = 8,
  parameter int unsigned COL    = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned KGAP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_cfg,
  input  logic [ADDR_W-1:0] num_vec,
  output logic              format,
  output logic [1:0]        inst_w,
  output logic              overwrite,
  output logic              flush,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RC_W = $clog2(ROW + COL);
  localparam int unsigned CW   = (ADDR_W > RC_W) ? ADDR_W : RC_W;

  state_t            state;
  state_t            nxt_c;
  logic [ADDR_W-1:0] nv_reg;
  logic              nv_zero_c;
  logic              cnt_zero_c;
  logic              cnt_load_c;
  logic [CW-1:0]     cnt_val_c;

  assign nv_zero_c = (nv_reg == '0);

  // Phase sequencing; multi-cycle phases leave when the counter reads zero.
  always_comb begin
    nxt_c = state;
    case (state)
      S_IDLE:  if (start) nxt_c = S_CLEAR;
      S_CLEAR: begin
        if (format == FMT_WS) nxt_c = S_KLOAD;
        else                  nxt_c = nv_zero_c ? S_DRAIN : S_EXEC;
      end
      S_KLOAD: begin
        if (cnt_zero_c) begin
          if (KGAP > 0) nxt_c = S_KGAP;
          else          nxt_c = nv_zero_c ? S_DRAIN : S_EXEC;
        end
      end
      S_KGAP:  if (cnt_zero_c) nxt_c = nv_zero_c ? S_DRAIN : S_EXEC;
      S_EXEC:  if (cnt_zero_c) nxt_c = S_DRAIN;
      S_DRAIN: if (cnt_zero_c) nxt_c = (format == FMT_WS) ? S_DONE : S_FLUSH;
      S_FLUSH: if (cnt_zero_c) nxt_c = S_DONE;
      S_DONE:  nxt_c = S_IDLE;
      default: nxt_c = S_IDLE;
    endcase
  end

  // Counter is reloaded with (phase length - 1) on every phase entry.
  always_comb begin
    cnt_load_c = (nxt_c != state);
    cnt_val_c  = '0;
    case (nxt_c)
      S_KLOAD: cnt_val_c = CW'(COL - 1);
      S_KGAP:  cnt_val_c = CW'(KGAP - 1);
      S_EXEC:  cnt_val_c = CW'(nv_reg) - CW'(1);
      S_DRAIN: cnt_val_c = CW'(ROW + COL - 2);
      S_FLUSH: cnt_val_c = CW'(ROW - 1);
      default: cnt_val_c = '0;
    endcase
  end

  seq_cnt #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .zero_c   (cnt_zero_c)
  );

  // State register plus outputs registered from the next state, so every
  // output lines up with the phase it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      nv_reg      <= '0;
      format      <= 1'b0;
      inst_w      <= INST_IDLE;
      overwrite   <= 1'b0;
      flush       <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= nxt_c;
      if (state == S_IDLE && start) begin
        format <= mode_cfg;
        nv_reg <= num_vec;
      end
      overwrite <= (nxt_c == S_CLEAR);
      flush     <= (nxt_c == S_FLUSH);
      done      <= (nxt_c == S_DONE);
      busy      <= (nxt_c != S_IDLE) && (nxt_c != S_DONE);
      mem_rd_en <= (nxt_c == S_KLOAD) || (nxt_c == S_EXEC);
      case (nxt_c)
        S_KLOAD: inst_w <= INST_LOAD;
        S_EXEC:  inst_w <= (format == FMT_WS) ? INST_EXEC : INST_LOAD;
        default: inst_w <= INST_IDLE;
      endcase
      // Address restarts at 0 on entry to each read phase.
      if ((nxt_c == S_KLOAD) || (nxt_c == S_EXEC)) begin
        mem_rd_addr <= (nxt_c == state) ? mem_rd_addr + ADDR_W'(1) : '0;
      end else begin
        mem_rd_addr <= '0;
      end
    end
  end

endmodule
